// File: rtl/drive_responder.sv
// Car drive responder: registered command decode, OFF/IDLE/FWD/REV motion FSM,
// BCD mileage odometer, per-side blinking turn lamps and 90-degree heading tracker.
module drive_responder #(
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned BLINK_DIV   = 50_000_000,
  parameter int unsigned TURN_CYCLES = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        power_now,
  input  logic [3:0]  answer,
  output logic        left_lamp,
  output logic        right_lamp,
  output logic [15:0] mileage,
  output logic [1:0]  heading,
  output logic [1:0]  motion,
  output logic        cmd_error
);

  localparam int unsigned TW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
  localparam int unsigned BW = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;
  localparam int unsigned RW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] TURN_LAST  = RW'(TURN_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    IDLE = 2'd1,
    FWD  = 2'd2,
    REV  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [3:0]         cmd;
  logic [3:0]         eff;
  logic               illegal;
  logic               moving;
  logic               turning;
  logic [TW-1:0]      presc;
  logic [RW-1:0]      turn_cnt;
  logic [1:0][BW-1:0] blink_cnt;
  logic [1:0]         lamp;
  logic [1:0]         lamp_prev;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd <= '0;
    end else begin
      cmd <= answer;
    end
  end

  // Illegal combinations and the whole command while OFF collapse to 0000.
  always_comb begin
    illegal   = (cmd[0] & cmd[1]) | (cmd[2] & cmd[3]);
    eff       = '0;
    if ((state != OFF) && !illegal) begin
      eff = cmd;
    end
    cmd_error = illegal && (state != OFF);
    moving    = (state == FWD) || (state == REV);
    turning   = moving && (eff[2] ^ eff[3]);
  end

  always_comb begin
    state_nxt = state;
    if (power_now) begin
      state_nxt = OFF;
    end else begin
      case (state)
        OFF:  state_nxt = IDLE;
        IDLE: begin
          if (eff[0]) begin
            state_nxt = FWD;
          end else if (eff[1]) begin
            state_nxt = REV;
          end
        end
        FWD:  if (!eff[0]) state_nxt = IDLE;
        REV:  if (!eff[1]) state_nxt = IDLE;
        default: state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Prescaler is held (not cleared) while idle; only power-off discards it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc   <= '0;
      mileage <= '0;
    end else if (power_now) begin
      presc   <= '0;
      mileage <= '0;
    end else if (moving) begin
      if (presc == TICK_LAST) begin
        presc   <= '0;
        mileage <= bcd_inc(mileage);
      end else begin
        presc <= presc + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      turn_cnt <= '0;
      heading  <= '0;
    end else if (power_now) begin
      turn_cnt <= '0;
      heading  <= '0;
    end else if (!turning) begin
      turn_cnt <= '0;
    end else if (turn_cnt == TURN_LAST) begin
      turn_cnt <= '0;
      heading  <= eff[3] ? (heading + 2'd1) : (heading - 2'd1);
    end else begin
      turn_cnt <= turn_cnt + RW'(1);
    end
  end

  // Index 0 is the left lamp (cmd[2]), index 1 the right lamp (cmd[3]).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lamp      <= '0;
      lamp_prev <= '0;
      blink_cnt <= '0;
    end else if (power_now) begin
      lamp      <= '0;
      lamp_prev <= '0;
      blink_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        lamp_prev[i] <= eff[2+i];
        if (!eff[2+i]) begin
          lamp[i]      <= 1'b0;
          blink_cnt[i] <= '0;
        end else if (!lamp_prev[i]) begin
          lamp[i]      <= 1'b1;
          blink_cnt[i] <= '0;
        end else if (blink_cnt[i] == BLINK_LAST) begin
          lamp[i]      <= ~lamp[i];
          blink_cnt[i] <= '0;
        end else begin
          blink_cnt[i] <= blink_cnt[i] + BW'(1);
        end
      end
    end
  end

  always_comb begin
    left_lamp  = lamp[0];
    right_lamp = lamp[1];
    motion     = state;
  end

endmodule

// File: tb/tb_drive_responder.sv
// Directed self-checking bench for drive_responder with small divider values
// (TICK_DIV=4, BLINK_DIV=2, TURN_CYCLES=3); edges numbered from the IDLE start of each task.
module tb_drive_responder;

  logic        clk;
  logic        rst;
  logic        power_now;
  logic [3:0]  answer;
  logic        left_lamp;
  logic        right_lamp;
  logic [15:0] mileage;
  logic [1:0]  heading;
  logic [1:0]  motion;
  logic        cmd_error;

  int checks = 0;
  int fails  = 0;

  drive_responder #(
    .TICK_DIV   (4),
    .BLINK_DIV  (2),
    .TURN_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .power_now (power_now),
    .answer    (answer),
    .left_lamp (left_lamp),
    .right_lamp(right_lamp),
    .mileage   (mileage),
    .heading   (heading),
    .motion    (motion),
    .cmd_error (cmd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fresh();
    answer    = 4'b0000;
    power_now = 1'b1;
    step(1);
    power_now = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; power_now = 1'b1; answer = 4'b0101;
    #2;
    checks++; if (motion !== 2'd0) begin fails++; $display("FAIL rst_motion: got %0d want 0", motion); end
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL rst_mileage: got %h want 0000", mileage); end
    checks++; if (heading !== 2'd0) begin fails++; $display("FAIL rst_heading: got %0d want 0", heading); end
    checks++; if ({left_lamp, right_lamp, cmd_error} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b want 000", {left_lamp, right_lamp, cmd_error}); end
    step(2);
    checks++; if (motion !== 2'd0) begin fails++; $display("FAIL rst_hold_motion: got %0d want 0", motion); end
    rst = 1'b1;
    step(1);
    checks++; if (motion !== 2'd0) begin fails++; $display("FAIL rst_off_powered: got %0d want 0", motion); end
  endtask

  task automatic test_forward();
    fresh();
    answer = 4'b0001; step(1);
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL fwd_latency: motion %0d want 1", motion); end
    step(1);
    checks++; if (motion !== 2'd2) begin fails++; $display("FAIL fwd_enter: motion %0d want 2", motion); end
    step(3);
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL fwd_m_e5: mileage %h want 0000", mileage); end
    step(1);
    checks++; if (mileage !== 16'h0001) begin fails++; $display("FAIL fwd_m_e6: mileage %h want 0001", mileage); end
    step(3);
    answer = 4'b0000; step(1);
    checks++; if (mileage !== 16'h0002) begin fails++; $display("FAIL fwd_m_e10: mileage %h want 0002", mileage); end
    step(1);
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL fwd_release: motion %0d want 1", motion); end
    checks++; if (mileage !== 16'h0002) begin fails++; $display("FAIL fwd_m_final: mileage %h want 0002", mileage); end
    answer = 4'b0001; step(2);
    checks++; if (motion !== 2'd2) begin fails++; $display("FAIL hold_reenter: motion %0d want 2", motion); end
    step(2);
    checks++; if (mileage !== 16'h0002) begin fails++; $display("FAIL hold_m_e15: mileage %h want 0002", mileage); end
    step(1);
    checks++; if (mileage !== 16'h0003) begin fails++; $display("FAIL hold_m_e16: mileage %h want 0003", mileage); end
    answer = 4'b0000;
  endtask

  task automatic test_turn_left();
    fresh();
    answer = 4'b0001; step(2);
    answer = 4'b0101; step(1);
    step(1);
    checks++; if ({left_lamp, right_lamp} !== 2'b10) begin fails++; $display("FAIL left_e4: lamps %b want 10", {left_lamp, right_lamp}); end
    step(1);
    checks++; if (left_lamp !== 1'b1) begin fails++; $display("FAIL left_e5: lamp %b want 1", left_lamp); end
    checks++; if (heading !== 2'd0) begin fails++; $display("FAIL left_h_e5: heading %0d want 0", heading); end
    step(1);
    checks++; if (left_lamp !== 1'b0) begin fails++; $display("FAIL left_e6: lamp %b want 0", left_lamp); end
    checks++; if (heading !== 2'd3) begin fails++; $display("FAIL left_h_e6: heading %0d want 3", heading); end
    answer = 4'b0001; step(1);
    checks++; if (left_lamp !== 1'b0) begin fails++; $display("FAIL left_e7: lamp %b want 0", left_lamp); end
    answer = 4'b0000;
  endtask

  task automatic test_turn_right();
    logic exp_lamp [4:10];
    logic [1:0] exp_head [4:10];
    exp_lamp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_head = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    fresh();
    answer = 4'b0001; step(2);
    answer = 4'b1001; step(1);
    for (int e = 4; e <= 10; e++) begin
      if (e == 9) answer = 4'b0001;
      step(1);
      checks++; if (right_lamp !== exp_lamp[e]) begin fails++; $display("FAIL right_lamp_e%0d: lamp %b want %b", e, right_lamp, exp_lamp[e]); end
      checks++; if (heading !== exp_head[e]) begin fails++; $display("FAIL right_head_e%0d: heading %0d want %0d", e, heading, exp_head[e]); end
    end
    answer = 4'b1001; step(1);
    answer = 4'b0001; step(2);
    answer = 4'b1001; step(3);
    checks++; if (heading !== 2'd2) begin fails++; $display("FAIL turn_clear_e16: heading %0d want 2", heading); end
    step(1);
    checks++; if (heading !== 2'd3) begin fails++; $display("FAIL turn_clear_e17: heading %0d want 3", heading); end
    answer = 4'b0000;
  endtask

  task automatic test_reverse_turn();
    fresh();
    answer = 4'b0010; step(2);
    checks++; if (motion !== 2'd3) begin fails++; $display("FAIL rev_enter: motion %0d want 3", motion); end
    answer = 4'b0110; step(3);
    checks++; if (heading !== 2'd0) begin fails++; $display("FAIL rev_h_e5: heading %0d want 0", heading); end
    step(1);
    checks++; if (heading !== 2'd3) begin fails++; $display("FAIL rev_h_e6: heading %0d want 3", heading); end
    checks++; if (mileage !== 16'h0001) begin fails++; $display("FAIL rev_m_e6: mileage %h want 0001", mileage); end
    answer = 4'b0000;
  endtask

  task automatic test_idle_no_turn();
    fresh();
    answer = 4'b0100; step(2);
    checks++; if (left_lamp !== 1'b1) begin fails++; $display("FAIL idle_lamp: lamp %b want 1", left_lamp); end
    step(4);
    checks++; if (heading !== 2'd0) begin fails++; $display("FAIL idle_heading: heading %0d want 0", heading); end
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL idle_motion: motion %0d want 1", motion); end
    answer = 4'b0000;
  endtask

  task automatic test_direction_switch();
    logic [1:0] exp_m [3:8];
    exp_m = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2};
    fresh();
    answer = 4'b0001; step(2);
    answer = 4'b0010;
    for (int e = 3; e <= 8; e++) begin
      if (e == 6) answer = 4'b0001;
      step(1);
      checks++; if (motion !== exp_m[e]) begin fails++; $display("FAIL switch_e%0d: motion %0d want %0d", e, motion, exp_m[e]); end
      checks++; if (cmd_error !== 1'b0) begin fails++; $display("FAIL switch_err_e%0d: cmd_error %b want 0", e, cmd_error); end
    end
    answer = 4'b0000;
  endtask

  task automatic test_cmd_error();
    fresh();
    answer = 4'b0011; step(1);
    checks++; if (cmd_error !== 1'b1) begin fails++; $display("FAIL err_0011: cmd_error %b want 1", cmd_error); end
    answer = 4'b0001; step(1);
    checks++; if (cmd_error !== 1'b0) begin fails++; $display("FAIL err_clear_e2: cmd_error %b want 0", cmd_error); end
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL err_idle_e2: motion %0d want 1", motion); end
    step(1);
    checks++; if (motion !== 2'd2) begin fails++; $display("FAIL err_fwd_e3: motion %0d want 2", motion); end
    answer = 4'b1101; step(1);
    checks++; if (cmd_error !== 1'b1) begin fails++; $display("FAIL err_1101: cmd_error %b want 1", cmd_error); end
    answer = 4'b0001; step(1);
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL err_as_zero: motion %0d want 1", motion); end
    checks++; if ({left_lamp, right_lamp} !== 2'b00) begin fails++; $display("FAIL err_lamps: lamps %b want 00", {left_lamp, right_lamp}); end
    step(1);
    answer = 4'b1100; step(1);
    checks++; if (cmd_error !== 1'b1) begin fails++; $display("FAIL err_1100_a: cmd_error %b want 1", cmd_error); end
    step(1);
    checks++; if (cmd_error !== 1'b1) begin fails++; $display("FAIL err_1100_b: cmd_error %b want 1", cmd_error); end
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL err_1100_idle: motion %0d want 1", motion); end
    answer = 4'b0000; step(1);
    checks++; if (cmd_error !== 1'b0) begin fails++; $display("FAIL err_end: cmd_error %b want 0", cmd_error); end
  endtask

  task automatic test_mileage_wrap();
    fresh();
    answer = 4'b0001; step(2);
    step(40);
    checks++; if (mileage !== 16'h0010) begin fails++; $display("FAIL wrap_0010: mileage %h want 0010", mileage); end
    step(360);
    checks++; if (mileage !== 16'h0100) begin fails++; $display("FAIL wrap_0100: mileage %h want 0100", mileage); end
    step(3599);
    checks++; if (mileage !== 16'h0999) begin fails++; $display("FAIL wrap_0999: mileage %h want 0999", mileage); end
    step(1);
    checks++; if (mileage !== 16'h1000) begin fails++; $display("FAIL wrap_1000: mileage %h want 1000", mileage); end
    step(35996);
    checks++; if (mileage !== 16'h9999) begin fails++; $display("FAIL wrap_9999: mileage %h want 9999", mileage); end
    step(3);
    checks++; if (mileage !== 16'h9999) begin fails++; $display("FAIL wrap_9999_hold: mileage %h want 9999", mileage); end
    step(1);
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL wrap_0000: mileage %h want 0000", mileage); end
    answer = 4'b0000;
  endtask

  task automatic test_power_off();
    fresh();
    answer = 4'b0001; step(2);
    answer = 4'b1001; step(3);
    answer = 4'b0001; step(1);
    checks++; if (heading !== 2'd1) begin fails++; $display("FAIL pwr_setup_h: heading %0d want 1", heading); end
    step(14);
    answer = 4'b1001; step(3);
    checks++; if (mileage !== 16'h0005) begin fails++; $display("FAIL pwr_pre_m: mileage %h want 0005", mileage); end
    checks++; if ({right_lamp, heading, motion} !== 5'b1_01_10) begin fails++; $display("FAIL pwr_pre_state: lamp/head/motion %b want 10110", {right_lamp, heading, motion}); end
    power_now = 1'b1; step(1);
    checks++; if (motion !== 2'd0) begin fails++; $display("FAIL pwr_motion: motion %0d want 0", motion); end
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL pwr_mileage: mileage %h want 0000", mileage); end
    checks++; if (heading !== 2'd0) begin fails++; $display("FAIL pwr_heading: heading %0d want 0", heading); end
    checks++; if ({left_lamp, right_lamp} !== 2'b00) begin fails++; $display("FAIL pwr_lamps: lamps %b want 00", {left_lamp, right_lamp}); end
    step(1);
    checks++; if ({motion, right_lamp} !== 3'b000) begin fails++; $display("FAIL pwr_ignore_cmd: motion/lamp %b want 000", {motion, right_lamp}); end
    power_now = 1'b0; answer = 4'b0001; step(1);
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL pwr_on_idle: motion %0d want 1", motion); end
    step(4);
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL pwr_presc_e30: mileage %h want 0000", mileage); end
    step(1);
    checks++; if (mileage !== 16'h0001) begin fails++; $display("FAIL pwr_presc_e31: mileage %h want 0001", mileage); end
    answer = 4'b0000;
  endtask

  task automatic test_async_reset();
    fresh();
    answer = 4'b0001; step(2);
    answer = 4'b1001; step(6);
    checks++; if ({mileage, heading, right_lamp} !== {16'h0001, 2'd1, 1'b1}) begin fails++; $display("FAIL arst_pre: mileage %h heading %0d lamp %b want 0001 1 1", mileage, heading, right_lamp); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (motion !== 2'd0) begin fails++; $display("FAIL arst_motion: motion %0d want 0", motion); end
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL arst_mileage: mileage %h want 0000", mileage); end
    checks++; if ({heading, left_lamp, right_lamp, cmd_error} !== 5'b0) begin fails++; $display("FAIL arst_misc: %b want 00000", {heading, left_lamp, right_lamp, cmd_error}); end
    step(1);
    answer = 4'b0001; power_now = 1'b0; rst = 1'b1;
    step(1);
    checks++; if (motion !== 2'd1) begin fails++; $display("FAIL arst_r1: motion %0d want 1", motion); end
    step(1);
    checks++; if (motion !== 2'd2) begin fails++; $display("FAIL arst_r2: motion %0d want 2", motion); end
    step(3);
    checks++; if (mileage !== 16'h0000) begin fails++; $display("FAIL arst_r5: mileage %h want 0000", mileage); end
    step(1);
    checks++; if (mileage !== 16'h0001) begin fails++; $display("FAIL arst_r6: mileage %h want 0001", mileage); end
    checks++; if (heading !== 2'd0) begin fails++; $display("FAIL arst_r6_h: heading %0d want 0", heading); end
    answer = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_turn_left();
    test_turn_right();
    test_reverse_turn();
    test_idle_no_turn();
    test_direction_switch();
    test_cmd_error();
    test_mileage_wrap();
    test_power_off();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/drive_responder.md
DRIVE_RESPONDER -- requirements
Module: drive_responder

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100_000_000, meaning clk cycles of motion per mileage unit.
REQ-002 The block SHALL have parameter BLINK_DIV, default 50_000_000, meaning clk cycles per turn-lamp half-period.
REQ-003 The block SHALL have parameter TURN_CYCLES, default 100_000_000, meaning clk cycles of moving-while-turning per 90-degree heading step.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port power_now, input, 1, 1 = car powered off.
REQ-008 The block SHALL have port answer, input, 4, drive command: [3] right, [2] left, [1] reverse, [0] forward.
REQ-009 The block SHALL have port left_lamp, output, 1, left indicator.
REQ-010 The block SHALL have port right_lamp, output, 1, right indicator.
REQ-011 The block SHALL have port mileage, output, 16, four BCD digits, units.
REQ-012 The block SHALL have port heading, output, 2, 0 N, 1 E, 2 S, 3 W.
REQ-013 The block SHALL have port motion, output, 2, FSM state code.
REQ-014 The block SHALL have port cmd_error, output, 1, one-cycle illegal-command pulse.

Function
REQ-015 answer SHALL be registered once; all behaviour acts on the registered copy (cmd), giving 1-cycle input latency.
REQ-016 FSM states SHALL be OFF (code 0), IDLE (1), FWD (2), REV (3), with the state code driven on motion.
- From OFF: go to IDLE when power_now=0.
- From IDLE: go to FWD on cmd[0] alone; go to REV on cmd[1] alone.
- From FWD or REV: go to IDLE when the motion bit drops.
- Any state: go to OFF when power_now=1; this has highest priority.
REQ-017 A direct FWD-to-REV or REV-to-FWD request SHALL go to IDLE for at least one cycle before entering the new direction.
REQ-018 cmd[0]&cmd[1] or cmd[2]&cmd[3] SHALL pulse cmd_error for one cycle and be treated as cmd=0000 for that cycle.
REQ-019 Prescaler SHALL count only in FWD/REV.
- At TICK_DIV-1, the prescaler wraps to 0 and mileage increments in BCD.
- Mileage 9999 SHALL wrap to 0000.
- On leaving FWD/REV to IDLE, the prescaler holds its value (not cleared).
REQ-020 Lamp x SHALL go to 1 in the cycle after cmd bit x rises.
- It toggles every BLINK_DIV cycles while the bit is held.
- It goes to 0 the cycle after the bit falls.
- Each lamp has its own blink counter.
REQ-021 Turn counter SHALL count while in FWD/REV with exactly one turn bit set.
- At TURN_CYCLES-1, heading += 1 (right) or -= 1 (left), modulo 4, and the counter clears.
- The counter clears whenever the turn condition is false.
- Reverse SHALL NOT invert the turn direction.
REQ-022 Entering OFF SHALL clear, in the same cycle: mileage, prescaler, turn counter, blink counters, lamps, and heading.
- cmd is ignored while in OFF.

Reset
REQ-023 rst=0 SHALL asynchronously set state OFF, cmd=0, all counters 0, and all outputs 0 (mileage 0x0000, heading 0, motion 0, cmd_error 0).
REQ-024 Release of rst SHALL take effect on the next clk edge.
- A reset asserted mid-count SHALL discard partial prescaler and turn progress.

Verification (TICK_DIV=4, BLINK_DIV=2, TURN_CYCLES=3)
REQ-025 Power on, answer=0001 for 9 cycles, then 0000.
- Response: motion=2 one cycle after cmd; mileage=0x0002; motion=1 after release.
REQ-026 answer=0101 held 4 cycles in FWD.
- Response: left_lamp pattern 1,1,0,0 (starting the cycle after cmd); heading=3 after 3 counted cycles.
REQ-027 Mileage preset to 0x9999, FWD for 4 cycles.
- Response: mileage=0x0000.
REQ-028 In FWD, answer switches 0001 to 0010.
- Response: motion goes 2, then 1 for at least one cycle, then 3; no cmd_error.
REQ-029 answer=0011 or 1100.
- Response: cmd_error=1 for exactly one cycle per such cycle; motion unchanged/IDLE; lamps 0.
REQ-030 power_now=1 while moving with mileage=0x0005, heading=1.
- Response: next cycle motion=0, mileage=0, heading=0, lamps 0.
- rst=0 mid-operation: all outputs 0 immediately, without waiting for clk.
